// File: rtl/gpu_mem_arb_pkg.sv
// Shared definitions for the GPU memory arbiter: bus widths, FSM state
// encoding and the read data returned for watchdog-aborted transactions.
package gpu_mem_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin select.
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   IDX_W    index granted most recently
//   grant      out  NUM_REQ  one-hot winner (0 when no request)
//   idx        out  IDX_W    binary winner index
//   any_req    out  1        at least one request present
// The search starts one past last_grant and wraps, so the most recent
// winner has the lowest priority.
module gpu_rr_picker #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  always_comb begin
    int unsigned cand;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      // last_grant < NUM_REQ and i <= NUM_REQ, so one subtraction wraps
      cand = 32'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing the GPU main external bus-master port among
// memory clients (0 = instruction fetch, 1 = vertex fetch, 2 = raster WB).
// Ports:
//   clk_clk, reset_reset_n          clock, synchronous active-low reset
//   req_valid/ready/write/addr/be/wdata  per-requester request channel
//   resp_valid/rdata/err            one-cycle completion pulse + data/abort flag
//   bus_address/byte_enable/read/write/write_data  registered bus master outputs
//   bus_acknowledge, bus_read_data  slave response
//   busy                            high whenever not IDLE
//   timeout_count                   saturating count of watchdog aborts
module gpu_mem_arbiter
  import gpu_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BE_W-1:0]   req_be,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         bus_address,
  output logic [BE_W-1:0]           bus_byte_enable,
  output logic                      bus_read,
  output logic                      bus_write,
  output logic [DATA_W-1:0]         bus_write_data,
  input  logic                      bus_acknowledge,
  input  logic [DATA_W-1:0]         bus_read_data,
  output logic                      busy,
  output logic [15:0]               timeout_count
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t             state, state_next;
  logic [IDX_W-1:0]   last_grant, cur_idx, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_hit;
  logic               accept, done_ok, done_to;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [BE_W-1:0]   be_arr    [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign be_arr[g]    = req_be[g*BE_W +: BE_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  gpu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any_req    (pick_any)
  );

  // The watchdog counts completed unacknowledged BUS cycles, so the
  // T-th strobe cycle without acknowledge is the one that aborts.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(WD_LAST));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Gated by reset so no requester sees a ready that is not honoured
        if (pick_any && reset_reset_n) begin
          accept     = 1'b1;
          state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_acknowledge) begin
          done_ok    = 1'b1;
          state_next = ST_RESP;
        end else if (wd_hit) begin
          done_to    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    req_ready = accept ? pick_grant : '0;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state           <= ST_IDLE;
      last_grant      <= IDX_W'(NUM_REQ - 1);
      cur_idx         <= '0;
      wd_cnt          <= '0;
      bus_address     <= '0;
      bus_byte_enable <= '0;
      bus_write_data  <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      resp_valid      <= '0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      busy            <= 1'b0;
      timeout_count   <= '0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != ST_IDLE);
      resp_valid <= '0;

      if (accept) begin
        cur_idx         <= pick_idx;
        bus_address     <= addr_arr[pick_idx];
        bus_byte_enable <= be_arr[pick_idx];
        bus_write_data  <= wdata_arr[pick_idx];
        bus_read        <= ~req_write[pick_idx];
        bus_write       <= req_write[pick_idx];
        wd_cnt          <= '0;
      end

      if (state == ST_BUS && !done_ok && !done_to) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (done_ok || done_to) begin
        bus_read  <= 1'b0;
        bus_write <= 1'b0;
        resp_err  <= done_to;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          resp_valid[i] <= (IDX_W'(i) == cur_idx);
        end
        if (done_to)        resp_rdata <= TIMEOUT_RDATA;
        else if (bus_write) resp_rdata <= '0;
        else                resp_rdata <= bus_read_data;
      end

      if (done_to && timeout_count != 16'hFFFF) begin
        timeout_count <= timeout_count + 16'd1;
      end

      if (state == ST_RESP) begin
        last_grant <= cur_idx;
      end
    end
  end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Self-checking bench for gpu_mem_arbiter (3 requesters, 8-cycle watchdog).
module tb_gpu_mem_arbiter;

  localparam int unsigned NR = 3;

  logic            clk_clk;
  logic            reset_reset_n;
  logic [NR-1:0]   req_valid, req_ready, req_write, resp_valid;
  logic [NR*30-1:0] req_addr;
  logic [NR*4-1:0]  req_be;
  logic [NR*32-1:0] req_wdata;
  logic [31:0]     resp_rdata, bus_write_data, bus_read_data;
  logic            resp_err, bus_read, bus_write, bus_acknowledge, busy;
  logic [29:0]     bus_address;
  logic [3:0]      bus_byte_enable;
  logic [15:0]     timeout_count;

  gpu_mem_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
    .busy(busy), .timeout_count(timeout_count)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int unsigned idx;
    logic        wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int unsigned k;        // ack on k-th strobe cycle; 0 = never ack
    logic [31:0] ack_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int unsigned idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_to = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int unsigned i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every response pulse pops and checks the oldest expectation
  always @(negedge clk_clk) begin
    if (reset_reset_n && resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_onehot", 32'(resp_valid), 32'(onehot(e.idx)));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Starts at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_txn(input vec_t v);
    int unsigned ncyc;
    exp_t e;
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*30 +: 30] = v.addr;
    req_be[v.idx*4 +: 4] = v.be;
    req_wdata[v.idx*32 +: 32] = v.wdata;
    bus_read_data = v.ack_data;
    #1;
    chk("req_ready", 32'(req_ready), 32'(onehot(v.idx)));
    e.idx = v.idx; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk_clk);
    // fields may change after ready; scramble them to prove they were latched
    req_valid = '0;
    req_addr  = {3{$urandom_range(0, 32'h3FFF_FFFF)}};
    req_wdata = {$urandom, $urandom, $urandom};
    req_be    = 12'($urandom);
    req_write = 3'($urandom);
    ncyc = (v.k == 0) ? 8 : v.k;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      chk("bus_read", 32'(bus_read), 32'(!v.wr));
      chk("bus_write", 32'(bus_write), 32'(v.wr));
      chk("bus_address", 32'(bus_address), 32'(v.addr));
      chk("bus_be", 32'(bus_byte_enable), 32'(v.be));
      if (v.wr) chk("bus_wdata", bus_write_data, v.wdata);
      chk("busy_bus", 32'(busy), 32'h1);
      if (c == v.k) bus_acknowledge = 1'b1;
      @(negedge clk_clk);
    end
    bus_acknowledge = 1'b0;
    if (v.k == 0) exp_to++;
    chk("strobe_end", 32'({bus_read, bus_write}), 32'h0);
    chk("resp_time", 32'(resp_valid), 32'(onehot(v.idx)));
    chk("timeout_count", 32'(timeout_count), 32'(exp_to));
    @(negedge clk_clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_resp", 32'(resp_valid), 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    int          gidx[$];
    int          gcyc[$];
    logic [29:0] faddr[NR];
    exp_t        e;

    vecs[0] = '{1, 1'b0, 30'h0000100, 4'hF, 32'h0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[1] = '{2, 1'b1, 30'h0001234, 4'b0101, 32'h00FF00FF, 3, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[2] = '{0, 1'b0, 30'h3FFFFFFF, 4'hF, 32'h0, 1, 32'h12345678, 32'h12345678, 1'b0};
    vecs[3] = '{1, 1'b0, 30'h0000200, 4'h3, 32'h0, 0, 32'hBADBAD00, 32'h0, 1'b1};
    vecs[4] = '{0, 1'b0, 30'h0000300, 4'hF, 32'h0, 8, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[5] = '{2, 1'b1, 30'h2AAAAAAA, 4'h8, 32'h1111, 0, 32'h5555AAAA, 32'h0, 1'b1};
    vecs[6] = '{1, 1'b1, 30'h15555555, 4'hF, 32'hFFFFFFFF, 7, 32'h00000077, 32'h0, 1'b0};

    reset_reset_n   = 1'b0;
    req_valid       = '1;
    req_write       = '0;
    req_addr        = '0;
    req_be          = '0;
    req_wdata       = '0;
    bus_acknowledge = 1'b0;
    bus_read_data   = '0;
    repeat (3) @(negedge clk_clk);

    // reset values
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_strobes", 32'({bus_read, bus_write}), 32'h0);
    chk("rst_bus_address", 32'(bus_address), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout_count", 32'(timeout_count), 32'h0);
    req_valid     = '0;
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // spurious acknowledge while idle
    bus_acknowledge = 1'b1;
    bus_read_data   = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      chk("spur_resp", 32'(resp_valid), 32'h0);
      chk("spur_busy", 32'(busy), 32'h0);
      chk("spur_strobe", 32'({bus_read, bus_write}), 32'h0);
    end
    bus_acknowledge = 1'b0;

    // fairness: all requesters valid continuously, slave acks at k = 1
    for (int i = 0; i < int'(NR); i++) begin
      faddr[i] = 30'(32'h100 * (i + 1));
      req_addr[i*30 +: 30] = faddr[i];
    end
    req_write = 3'b100;
    req_be    = '1;
    req_valid = '1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      #1;
      if (req_ready != '0) begin
        int w;
        w = 0;
        for (int i = 0; i < int'(NR); i++) if (req_ready[i]) w = i;
        gidx.push_back(w);
        gcyc.push_back(cyc);
        e.idx   = w;
        e.err   = 1'b0;
        e.rdata = (w == 2) ? 32'h0 : ({2'b10, faddr[w]} ^ 32'h0F0F0F0F);
        sb.push_back(e);
      end
      bus_acknowledge = bus_read | bus_write;
      bus_read_data   = {2'b10, bus_address} ^ 32'h0F0F0F0F;
      @(negedge clk_clk);
    end
    req_valid       = '0;
    bus_acknowledge = 1'b0;
    chk("fair_count", 32'(gidx.size()), 32'd6);
    for (int g = 0; g < gidx.size() && g < 6; g++) begin
      chk("fair_order", 32'(gidx[g]), 32'(g % 3));
      chk("fair_cycle", 32'(gcyc[g]), 32'(3 * g));
    end
    @(negedge clk_clk);

    // table-driven transactions
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // reset in the middle of a bus cycle
    run_txn('{0, 1'b0, 30'h0000400, 4'hF, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0});
    req_valid = 3'b010;
    req_write = '0;
    req_addr[30 +: 30] = 30'h0000500;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h2);
    @(negedge clk_clk);
    req_valid = '0;
    chk("mid_strobe", 32'(bus_read), 32'h1);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk("mid_rst_strobe", 32'({bus_read, bus_write}), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_resp", 32'(resp_valid), 32'h0);
    chk("mid_rst_tocount", 32'(timeout_count), 32'h0);
    exp_to = 0;
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("mid_post_resp", 32'(resp_valid), 32'h0);
    req_valid = '1;
    req_write = '0;
    req_addr[0 +: 30] = 30'h0000600;
    bus_read_data = 32'h600D600D;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    e.idx = 0; e.rdata = 32'h600D600D; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk_clk);
    req_valid = '0;
    chk("mid_post_addr", 32'(bus_address), 32'h0000600);
    bus_acknowledge = 1'b1;
    @(negedge clk_clk);
    bus_acknowledge = 1'b0;
    chk("mid_post_resp_pulse", 32'(resp_valid), 32'h1);
    repeat (3) @(negedge clk_clk);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/gpu_mem_arbiter.md
# gpu_mem_arbiter

Round-robin arbiter that shares the single GPU main external bus-master port (30-bit word address, 4-bit byte enable, read/write strobes held until acknowledge) among the pipeline stages that touch memory: instruction fetch, vertex fetch and raster pixel write-back. Each requester gets a one-transaction-at-a-time valid/ready request channel and a one-cycle response pulse. A watchdog terminates bus cycles that never acknowledge, so a wedged slave cannot hang the pipeline.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..8; index 0 = instruction fetch, 1 = vertex fetch, 2 = raster write-back.
- TIMEOUT_CYCLES, 1024: bus cycles without acknowledge before abort; 0 disables the watchdog.

Ports:
- clk_clk  in  1  single clock; all logic is on the rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*30  packed word addresses; requester i is at [30i+29:30i].
- req_be  in  NUM_REQ*4  packed byte enables.
- req_wdata  in  NUM_REQ*32  packed write data.
- resp_valid  out  NUM_REQ  one-hot completion pulse.
- resp_rdata  out  32  read data, shared by all requesters, valid with resp_valid.
- resp_err  out  1  1 = transaction aborted by the watchdog, valid with resp_valid.
- bus_address  out  30  to gpu_main_external_interface_address.
- bus_byte_enable  out  4  byte enables.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_write_data  out  32  write data.
- bus_acknowledge  in  1  slave acknowledge.
- bus_read_data  in  32  slave read data.
- busy  out  1  high in every state except IDLE.
- timeout_count  out  16  saturating count of watchdog aborts.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any req_valid bit is set, choose the winner by round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ.
  - Pulse req_ready[winner] for this cycle.
  - Latch the winner's write, addr, be and wdata, plus its index.
  - Go to BUS.
- BUS: drive bus_read or bus_write from the latched fields. All bus outputs stay constant for the whole state.
  - On bus_acknowledge: capture bus_read_data (writes capture 0) and go to RESP with err = 0.
  - Else, when the watchdog reaches TIMEOUT_CYCLES: set err = 1, rdata = 0, increment timeout_count (saturating at 0xFFFF), go to RESP.
- RESP: pulse resp_valid[index] with resp_rdata and resp_err, set last_grant = index, go to IDLE.
- Writes also get a resp_valid pulse; it signals write completion.
- Requester obligations:
  - Hold req_* fields stable while valid and not ready.
  - Do not drop valid before ready.
  - The fields may change the cycle after ready.
- The arbiter ignores bus_acknowledge in IDLE and RESP; spurious acknowledges have no effect.
- If acknowledge and watchdog expiry occur in the same cycle, the acknowledge wins (err = 0).
- Watchdog counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to BUS.
  - Increments in each BUS cycle without acknowledge.
- Reset in any state returns to IDLE. The in-flight transaction is dropped with no response, and the bus strobes drop in the same edge.

## Timing
- Reset values:
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_err, bus_*, busy, timeout_count.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Outputs are registered except req_ready, which is decoded from state and req_valid in IDLE.
- Cycle numbering, with acceptance at cycle t:
  - Strobes are high from t+1.
  - An acknowledge sampled at cycle t+k (k ≥ 1) gives resp_valid at t+k+1 and IDLE at t+k+2.
  - The next acceptance can happen no earlier than t+k+2.
- Minimum issue interval is 3 cycles (k = 1).
- A timeout with TIMEOUT_CYCLES = T asserts strobes for exactly T cycles, then resp_valid the following cycle.

## Structure
- Package gpu_mem_arb_pkg holds:
  - ADDR_W = 30, DATA_W = 32, BE_W = 4.
  - The state enum {IDLE, BUS, RESP}.
  - The TIMEOUT_RDATA constant (32'h0).
- Sub-module gpu_rr_picker: combinational round-robin select. Inputs: request vector and last_grant. Outputs: one-hot grant, binary index, any-request flag. Parameterized by NUM_REQ.

## Test plan
- Single read: req 1 at addr 0x0000100, slave acks 2 cycles after the strobe with 0xCAFEF00D -> ready[1] at t, bus_read high t+1..t+2, resp_valid[1] at t+3 with rdata 0xCAFEF00D, err 0.
- Fairness: all three requesters valid continuously, ack at k = 1 -> grant order 0,1,2,0,1,2, one grant every 3 cycles.
- Write: req 2 writes 0x00FF00FF with be = 4'b0101 -> bus_write_data and bus_byte_enable match, held until ack; resp_valid[2] with rdata 0.
- Timeout: TIMEOUT_CYCLES = 8, no ack -> strobe high exactly 8 cycles, resp_err = 1, rdata 0, timeout_count = 1; ack on cycle 8 instead -> err 0.
- Reset mid-BUS: deassert reset_reset_n during a strobe -> next edge strobes 0, no resp_valid, busy 0, requester 0 is granted first afterwards.
- Spurious ack in IDLE -> no resp_valid, state unchanged.
